// File: rtl/fir_tap_sequencer_pkg.sv
// Shared types and sizing constants for the FIR tap sequencer.
package fir_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  localparam int         NUM_TAPS   = 5;
  localparam logic [2:0] FLUSH_LEN  = 3'd4;
  localparam logic [1:0] OBUF_DEPTH = 2'd2;
  localparam logic [2:0] WARM_MAX   = 3'd4;

  // A result is "warm" while fewer than WARM_MAX real samples precede it.
  function automatic logic is_warm(input logic [2:0] cnt);
    return cnt < WARM_MAX;
  endfunction

endpackage

// File: rtl/fir_tap_sequencer_if.sv
// Sample-in / result-out streams of the tap sequencer.
// slave = sequencer side, master = sample source plus result sink.
interface fir_tap_sequencer_if #(
  parameter int DATA_W = 8
) ();
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_warm;
  logic              m_ready;

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_warm
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_warm
  );
endinterface

// File: rtl/fir_tap_sequencer_out_buf.sv
// fir_out_buf: 2-entry FIFO of {warm, data}; push and pop may coincide even when full.
module fir_out_buf
  import fir_ctrl_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              push_warm,
  input  logic              pop_req,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_warm,
  output logic [1:0]        count
);

  logic [DATA_W:0] mem_q [int'(OBUF_DEPTH)];
  logic [DATA_W:0] mem_d [int'(OBUF_DEPTH)];
  logic            rd_q, rd_d;
  logic            wr_q, wr_d;
  logic [1:0]      count_q, count_d;
  logic            do_push, do_pop;

  always_comb begin
    mem_d   = mem_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    do_pop  = pop_req && (count_q != 2'd0);
    do_push = push && ((count_q < OBUF_DEPTH) || do_pop);
    if (clear) begin
      rd_d    = 1'b0;
      wr_d    = 1'b0;
      count_d = 2'd0;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = {push_warm, push_data};
        wr_d        = wr_q + 1'b1;
      end
      if (do_pop) begin
        rd_d = rd_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(OBUF_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      count_q <= 2'd0;
    end else begin
      mem_q   <= mem_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  assign out_valid = (count_q != 2'd0);
  assign out_data  = mem_q[rd_q][DATA_W-1:0];
  assign out_warm  = mem_q[rd_q][DATA_W];
  assign count     = count_q;

endmodule

// File: rtl/fir_tap_sequencer.sv
// fir_tap_sequencer: sample history, result capture and warm-up/clear/flush control for a 5-tap FIR.
// Macro FIR_TAIL_FLUSH_EN enables the FLUSH state (4 zero injections); otherwise flush acts as clear.
module fir_tap_sequencer
  import fir_ctrl_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int FILT_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                clear,
  input  logic                flush,
  fir_tap_sequencer_if.slave  io,
  output logic [DATA_W-1:0]   tap0,
  output logic [DATA_W-1:0]   tap1,
  output logic [DATA_W-1:0]   tap2,
  output logic [DATA_W-1:0]   tap3,
  output logic [DATA_W-1:0]   tap4,
  input  logic [DATA_W-1:0]   filt_in,
  output logic                busy,
  output logic                flush_done
);

  // One stage covers the tap register itself, the rest match the filter latency.
  localparam int PIPE_LEN = FILT_LAT + 1;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   tap_q [NUM_TAPS];
  logic [DATA_W-1:0]   tap_d [NUM_TAPS];
  logic [2:0]          warm_cnt_q, warm_cnt_d;
  logic [PIPE_LEN-1:0] vld_q, vld_d;
  logic [PIPE_LEN-1:0] wflag_q, wflag_d;
`ifdef FIR_TAIL_FLUSH_EN
  logic [PIPE_LEN-1:0] last_q, last_d;
  logic [2:0]          inj_cnt_q, inj_cnt_d;
`else
  logic                flush_done_q, flush_done_d;
`endif

  logic       clear_all;
  logic [3:0] inflight_cnt;
  logic       credit_ok;
  logic       accept;
  logic       inject;
  logic       launch;
  logic       push;
  logic [1:0] buf_count;
  logic       buf_valid;
  logic [DATA_W-1:0] buf_data;
  logic       buf_warm;

`ifdef FIR_TAIL_FLUSH_EN
  assign clear_all = clear;
`else
  assign clear_all = clear | flush;
`endif

  always_comb begin
    inflight_cnt = 4'd0;
    for (int i = 0; i < PIPE_LEN; i++) begin
      inflight_cnt = inflight_cnt + {3'd0, vld_q[i]};
    end
  end

  assign credit_ok  = ({2'd0, buf_count} + inflight_cnt) < 4'd2;
  assign io.s_ready = (state_q == RUN) && credit_ok;
  assign accept     = io.s_valid && io.s_ready && !clear_all;
`ifdef FIR_TAIL_FLUSH_EN
  assign inject     = (state_q == FLUSH) && credit_ok && (inj_cnt_q < FLUSH_LEN) && !clear_all;
  assign flush_done = push && last_q[PIPE_LEN-1];
`else
  assign inject     = 1'b0;
  assign flush_done = flush_done_q;
`endif
  assign launch     = accept || inject;
  assign push       = vld_q[PIPE_LEN-1] && !clear_all;

  always_comb begin
    state_d    = state_q;
    tap_d      = tap_q;
    warm_cnt_d = warm_cnt_q;
    vld_d      = vld_q;
    wflag_d    = wflag_q;
`ifdef FIR_TAIL_FLUSH_EN
    last_d     = last_q;
    inj_cnt_d  = inj_cnt_q;
`else
    flush_done_d = flush;
`endif
    if (clear_all) begin
      for (int i = 0; i < NUM_TAPS; i++) begin
        tap_d[i] = '0;
      end
      warm_cnt_d = 3'd0;
      vld_d      = '0;
`ifdef FIR_TAIL_FLUSH_EN
      last_d     = '0;
      inj_cnt_d  = 3'd0;
      if (state_q == FLUSH) begin
        state_d = RUN;
      end
`endif
    end else begin
      vld_d   = {vld_q[PIPE_LEN-2:0], launch};
      wflag_d = {wflag_q[PIPE_LEN-2:0], is_warm(warm_cnt_q)};
      if (launch) begin
        for (int i = NUM_TAPS - 1; i > 0; i--) begin
          tap_d[i] = tap_q[i-1];
        end
        tap_d[0] = accept ? io.s_data : '0;
      end
      // Zero injections leave the warm count alone so flush tails inherit the current flag.
      if (accept && is_warm(warm_cnt_q)) begin
        warm_cnt_d = warm_cnt_q + 3'd1;
      end
`ifdef FIR_TAIL_FLUSH_EN
      last_d = {last_q[PIPE_LEN-2:0], inject && (inj_cnt_q == FLUSH_LEN - 3'd1)};
      if (inject) begin
        inj_cnt_d = inj_cnt_q + 3'd1;
      end
`endif
      case (state_q)
        IDLE: begin
          if (enable) state_d = RUN;
        end
        RUN: begin
          if (!enable) state_d = IDLE;
`ifdef FIR_TAIL_FLUSH_EN
          if (flush) begin
            state_d   = FLUSH;
            inj_cnt_d = 3'd0;
          end
        end
        FLUSH: begin
          if (flush_done) state_d = RUN;
`endif
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      for (int i = 0; i < NUM_TAPS; i++) begin
        tap_q[i] <= '0;
      end
      warm_cnt_q <= 3'd0;
      vld_q      <= '0;
      wflag_q    <= '0;
`ifdef FIR_TAIL_FLUSH_EN
      last_q     <= '0;
      inj_cnt_q  <= 3'd0;
`else
      flush_done_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tap_q      <= tap_d;
      warm_cnt_q <= warm_cnt_d;
      vld_q      <= vld_d;
      wflag_q    <= wflag_d;
`ifdef FIR_TAIL_FLUSH_EN
      last_q     <= last_d;
      inj_cnt_q  <= inj_cnt_d;
`else
      flush_done_q <= flush_done_d;
`endif
    end
  end

  fir_out_buf #(.DATA_W(DATA_W)) u_out_buf (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear_all),
    .push      (push),
    .push_data (filt_in),
    .push_warm (wflag_q[PIPE_LEN-1]),
    .pop_req   (io.m_ready),
    .out_valid (buf_valid),
    .out_data  (buf_data),
    .out_warm  (buf_warm),
    .count     (buf_count)
  );

  assign io.m_valid = buf_valid;
  assign io.m_data  = buf_data;
  assign io.m_warm  = buf_warm;

  assign tap0 = tap_q[0];
  assign tap1 = tap_q[1];
  assign tap2 = tap_q[2];
  assign tap3 = tap_q[3];
  assign tap4 = tap_q[4];

  assign busy = (state_q != IDLE) || (vld_q != '0) || (buf_count != 2'd0);

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Scoreboard bench for fir_tap_sequencer with a registered h = 1,2,3,2,1 filter model.
// Honours FIR_TAIL_FLUSH_EN for the impulse/flush scenario.
module tb_fir_tap_sequencer;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       clear;
  logic       flush;
  logic [7:0] tap0, tap1, tap2, tap3, tap4;
  logic [7:0] filt;
  logic       busy;
  logic       flush_done;

  int n_compared   = 0;
  int n_mismatched = 0;
  int fd_cnt       = 0;

  // Expected results as {warm, data}, oldest first.
  logic [8:0] exp_q [$];
  logic [8:0] mon_e;

  fir_tap_sequencer_if #(.DATA_W(8)) bus ();

  fir_tap_sequencer #(.DATA_W(8), .FILT_LAT(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .clear      (clear),
    .flush      (flush),
    .io         (bus.slave),
    .tap0       (tap0),
    .tap1       (tap1),
    .tap2       (tap2),
    .tap3       (tap3),
    .tap4       (tap4),
    .filt_in    (filt),
    .busy       (busy),
    .flush_done (flush_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Filter under control: one register, result truncated mod 256.
  always @(posedge clk or posedge rst) begin
    if (rst) filt <= 8'd0;
    else     filt <= tap0 + {tap1[6:0], 1'b0} + (tap2 + {tap2[6:0], 1'b0}) + {tap3[6:0], 1'b0} + tap4;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every output handshake.
  always @(negedge clk) begin
    if (!rst && bus.m_valid && bus.m_ready) begin
      if (exp_q.size() == 0) begin
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL unexpected_result: got %0d, expected no result", bus.m_data);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("m_data", 32'(bus.m_data), 32'(mon_e[7:0]));
        checkOutput("m_warm", 32'(bus.m_warm), 32'(mon_e[8]));
      end
    end
    if (flush_done) fd_cnt++;
  end

  task automatic applyStimulus(input logic [7:0] d, input logic expect_it,
                               input logic [7:0] exp_d, input logic exp_w);
    int n;
    if (expect_it) exp_q.push_back({exp_w, exp_d});
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    n = 0;
    while (!bus.s_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      checkOutput("s_ready_timeout", 32'(bus.s_ready), 32'd1);
    end else begin
      @(posedge clk); #1;
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.m_valid) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic clearPulse();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic checkTapsZero(input string tag);
    checkOutput({tag, "_tap0"}, 32'(tap0), 32'd0);
    checkOutput({tag, "_tap1"}, 32'(tap1), 32'd0);
    checkOutput({tag, "_tap2"}, 32'(tap2), 32'd0);
    checkOutput({tag, "_tap3"}, 32'(tap3), 32'd0);
    checkOutput({tag, "_tap4"}, 32'(tap4), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc;
    int vcount;
    logic [7:0] step_exp [10];
    logic [7:0] wrap_exp [6];
    step_exp = '{8'd10, 8'd30, 8'd60, 8'd80, 8'd90, 8'd90, 8'd90, 8'd90, 8'd90, 8'd90};
    // 100*(1,3,6,8,9,9) mod 256
    wrap_exp = '{8'd100, 8'd44, 8'd88, 8'd32, 8'd132, 8'd132};

    rst = 1'b1; enable = 1'b0; clear = 1'b0; flush = 1'b0;
    bus.s_valid = 1'b0; bus.s_data = 8'd0; bus.m_ready = 1'b1;
    #1;
    checkOutput("rst_s_ready", 32'(bus.s_ready), 32'd0);
    checkOutput("rst_m_valid", 32'(bus.m_valid), 32'd0);
    checkOutput("rst_m_data",  32'(bus.m_data),  32'd0);
    checkOutput("rst_m_warm",  32'(bus.m_warm),  32'd0);
    checkOutput("rst_busy",    32'(busy),        32'd0);
    checkOutput("rst_flush_done", 32'(flush_done), 32'd0);
    checkTapsZero("rst");
    cycles(2);
    rst = 1'b0;
    cycles(1);
    enable = 1'b1;
    cycles(1);

    // Impulse
    applyStimulus(8'd1, 1'b1, 8'd1, 1'b1);
`ifdef FIR_TAIL_FLUSH_EN
    exp_q.push_back({1'b1, 8'd2});
    exp_q.push_back({1'b1, 8'd3});
    exp_q.push_back({1'b1, 8'd2});
    exp_q.push_back({1'b1, 8'd1});
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    acc = 0;
    while (fd_cnt == 0 && acc < 50) begin
      @(posedge clk); #1;
      acc++;
    end
    waitDrain();
    cycles(3);
`else
    // warm count reaches 4 before the last zero, so its result is not warm
    applyStimulus(8'd0, 1'b1, 8'd2, 1'b1);
    applyStimulus(8'd0, 1'b1, 8'd3, 1'b1);
    applyStimulus(8'd0, 1'b1, 8'd2, 1'b1);
    applyStimulus(8'd0, 1'b1, 8'd1, 1'b0);
    waitDrain();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    cycles(3);
`endif
    checkOutput("flush_done_count", 32'(fd_cnt), 32'd1);
    checkTapsZero("flush");
    checkOutput("flush_s_ready", 32'(bus.s_ready), 32'd1);

    // Step
    clearPulse();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(8'd10, 1'b1, step_exp[i], (i < 4) ? 1'b1 : 1'b0);
    end
    waitDrain();

    // Wrap
    clearPulse();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(8'd100, 1'b1, wrap_exp[i], (i < 4) ? 1'b1 : 1'b0);
    end
    waitDrain();

    // Backpressure
    clearPulse();
    bus.m_ready = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = 8'd5;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.s_ready) begin
        acc++;
        if (acc == 1) exp_q.push_back({1'b1, 8'd5});
        else if (acc == 2) exp_q.push_back({1'b1, 8'd15});
      end
      @(posedge clk); #1;
    end
    bus.s_valid = 1'b0;
    checkOutput("bp_accepts", 32'(acc), 32'd2);
    checkOutput("bp_s_ready", 32'(bus.s_ready), 32'd0);
    checkOutput("bp_m_valid", 32'(bus.m_valid), 32'd1);
    checkOutput("bp_busy",    32'(busy),        32'd1);
    bus.m_ready = 1'b1;
    waitDrain();

    // Clear mid-stream with a full buffer
    clearPulse();
    bus.m_ready = 1'b0;
    applyStimulus(8'd7, 1'b0, 8'd0, 1'b0);
    applyStimulus(8'd7, 1'b0, 8'd0, 1'b0);
    cycles(3);
    checkOutput("clr_full_m_valid", 32'(bus.m_valid), 32'd1);
    clearPulse();
    checkOutput("clr_m_valid", 32'(bus.m_valid), 32'd0);
    checkTapsZero("clr");
    bus.m_ready = 1'b1;
    applyStimulus(8'd9, 1'b1, 8'd9, 1'b1);
    waitDrain();

    // Async reset with a result in flight
    applyStimulus(8'd3, 1'b0, 8'd0, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("arst_s_ready", 32'(bus.s_ready), 32'd0);
    checkOutput("arst_m_valid", 32'(bus.m_valid), 32'd0);
    checkOutput("arst_m_data",  32'(bus.m_data),  32'd0);
    checkOutput("arst_m_warm",  32'(bus.m_warm),  32'd0);
    checkOutput("arst_busy",    32'(busy),        32'd0);
    checkOutput("arst_tap0",    32'(tap0),        32'd0);
    cycles(2);
    rst = 1'b0;
    vcount = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus.m_valid) vcount++;
    end
    checkOutput("arst_no_output", 32'(vcount), 32'd0);
    applyStimulus(8'd4, 1'b1, 8'd4, 1'b1);
    waitDrain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
